// File: rtl/mcpu_button_debounce.sv
// Pushbutton conditioner: two-flop synchronizer, counter-qualified debounce FSM,
// registered press/release/long-press pulses and a held flag, all in the clk domain.
module mcpu_button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic held
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned LW = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] L_LAST = LW'((LONG_CYCLES > 0) ? LONG_CYCLES - 1 : 0);
    localparam logic [LW-1:0] L_MAX  = LW'(LONG_CYCLES);
    localparam logic RELEASED_PIN = ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t state, state_next;
    logic [DW-1:0] dcnt, dcnt_next;
    logic [LW-1:0] lcnt, lcnt_next;
    logic sync1, sync2, s;
    logic accept_press, accept_release;
    logic level_next, press_next, release_next, long_next, held_next;

    // Flops preset to the released pin level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= RELEASED_PIN;
            sync2 <= RELEASED_PIN;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    assign s = ACTIVE_LOW ? ~sync2 : sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            dcnt          <= '0;
            lcnt          <= '0;
            btn_level     <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            held          <= 1'b0;
        end else begin
            state         <= state_next;
            dcnt          <= dcnt_next;
            lcnt          <= lcnt_next;
            btn_level     <= level_next;
            press         <= press_next;
            release_pulse <= release_next;
            long_press    <= long_next;
            held          <= held_next;
        end
    end

    always_comb begin
        state_next = state;
        dcnt_next  = dcnt;
        case (state)
            IDLE: begin
                if (s) begin
                    state_next = PRESS_WAIT;
                    dcnt_next  = DW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_next = IDLE;
                    dcnt_next  = '0;
                end else if (dcnt == D_LAST) begin
                    state_next = PRESSED;
                    dcnt_next  = '0;
                end else begin
                    dcnt_next = dcnt + DW'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_next = RELEASE_WAIT;
                    dcnt_next  = DW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_next = PRESSED;
                    dcnt_next  = '0;
                end else if (dcnt == D_LAST) begin
                    state_next = IDLE;
                    dcnt_next  = '0;
                end else begin
                    dcnt_next = dcnt + DW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                dcnt_next  = '0;
            end
        endcase
    end

    assign accept_press   = (state == PRESS_WAIT)   &&  s && (dcnt == D_LAST);
    assign accept_release = (state == RELEASE_WAIT) && !s && (dcnt == D_LAST);

    // lcnt saturates at LONG_CYCLES, so the LONG_CYCLES-1 match fires once per press.
    always_comb begin
        press_next   = accept_press;
        release_next = accept_release;
        level_next   = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
        lcnt_next    = lcnt;
        long_next    = 1'b0;
        held_next    = held;
        if (LONG_CYCLES != 0) begin
            if (accept_press) begin
                lcnt_next = '0;
            end else if ((state == PRESSED) || (state == RELEASE_WAIT)) begin
                if (lcnt == L_LAST) begin
                    long_next = 1'b1;
                    held_next = 1'b1;
                end
                if (lcnt != L_MAX) begin
                    lcnt_next = lcnt + LW'(1);
                end
            end
        end
        if (accept_release) begin
            held_next = 1'b0;
        end
    end

endmodule

// File: tb/tb_mcpu_button_debounce.sv
// Self-checking bench for mcpu_button_debounce: directed phases plus random bouncing,
// compared each cycle against a run-length model of the debounce rules.
module tb_mcpu_button_debounce;

    localparam int D = 4;
    localparam int L = 16;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic btn_level, press, release_pulse, long_press, held;

    int errors = 0;
    int checks = 0;

    // Model: synchronized sample is the pin from two edges ago; the level flips
    // after D consecutive synchronized samples that disagree with it.
    logic m_q[$];
    bit   m_lvl, m_press, m_rel, m_long, m_held;
    int   m_run, m_cyc, m_acc;

    int n_press, n_rel, n_long;
    int last_press_cyc, last_rel_cyc, last_long_cyc;

    always #5 clk = ~clk;

    mcpu_button_debounce #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .press(press),
        .release_pulse(release_pulse),
        .long_press(long_press),
        .held(held)
    );

    task automatic modelReset();
        m_q     = '{1'b1, 1'b1};
        m_lvl   = 1'b0;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        m_held  = 1'b0;
        m_run   = 0;
        m_acc   = -1000;
    endtask

    task automatic modelEdge(input logic sample);
        bit was, s;
        m_cyc++;
        if (rst) begin
            modelReset();
            return;
        end
        was     = m_lvl;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        s = !m_q.pop_front();
        m_q.push_back(sample);
        if (s != m_lvl) m_run++;
        else            m_run = 0;
        if (m_run == D) begin
            m_lvl = !m_lvl;
            m_run = 0;
            if (m_lvl) begin
                m_press = 1'b1;
                m_acc   = m_cyc;
            end else begin
                m_rel = 1'b1;
            end
        end
        if (was && (m_cyc == m_acc + L)) m_long = 1'b1;
        m_held = m_lvl && (m_cyc >= m_acc + L);
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b at cycle %0d", tag, obs, exp, m_cyc);
        end
    endtask

    task automatic checkInt(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkBit("btn_level", btn_level, m_lvl);
        checkBit("press", press, m_press);
        checkBit("release", release_pulse, m_rel);
        checkBit("long_press", long_press, m_long);
        checkBit("held", held, m_held);
        if (press === 1'b1) begin
            n_press++;
            last_press_cyc = m_cyc;
        end
        if (release_pulse === 1'b1) begin
            n_rel++;
            last_rel_cyc = m_cyc;
        end
        if (long_press === 1'b1) begin
            n_long++;
            last_long_cyc = m_cyc;
        end
    endtask

    task automatic applyStimulus(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            btn_in = b;
            @(posedge clk);
            modelEdge(btn_in);
            #1;
            checkOutput();
        end
    endtask

    // Called 1 time unit after an edge; asserts reset between edges.
    task automatic pulseReset(input logic b, input int n);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput();
        applyStimulus(b, n);
        rst = 1'b0;
    endtask

    initial begin
        int chg, p0, r0, l0;
        rst = 1'b1;
        btn_in = 1'b0;
        m_cyc = 0;
        n_press = 0; n_rel = 0; n_long = 0;
        last_press_cyc = -1; last_rel_cyc = -1; last_long_cyc = -1;
        modelReset();

        $display("[TB] reset with button pressed");
        #1;
        checkOutput();
        applyStimulus(1'b0, 3);
        rst = 1'b0;
        chg = m_cyc;
        applyStimulus(1'b0, 10);
        checkInt("reset_press_latency", last_press_cyc - chg, 6);
        applyStimulus(1'b1, 10);

        $display("[TB] clean short press");
        p0 = n_press; l0 = n_long;
        chg = m_cyc;
        applyStimulus(1'b0, 10);
        checkInt("press_latency", last_press_cyc - chg, 6);
        chg = m_cyc;
        applyStimulus(1'b1, 10);
        checkInt("release_latency", last_rel_cyc - chg, 6);
        checkInt("short_press_count", n_press - p0, 1);
        checkInt("short_no_long", n_long - l0, 0);

        $display("[TB] press bounce");
        p0 = n_press;
        applyStimulus(1'b0, 2); applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 2); applyStimulus(1'b1, 2);
        applyStimulus(1'b1, 10);
        checkInt("bounce_no_press", n_press - p0, 0);

        $display("[TB] release bounce");
        applyStimulus(1'b0, 10);
        r0 = n_rel;
        applyStimulus(1'b1, 2); applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 2); applyStimulus(1'b0, 2);
        applyStimulus(1'b0, 4);
        checkInt("bounce_no_release", n_rel - r0, 0);
        applyStimulus(1'b1, 10);

        $display("[TB] long press");
        p0 = n_press; l0 = n_long;
        applyStimulus(1'b0, 40);
        checkInt("long_latency", last_long_cyc - last_press_cyc, 16);
        checkInt("long_press_count", n_press - p0, 1);
        checkInt("long_once", n_long - l0, 1);
        applyStimulus(1'b1, 10);

        $display("[TB] hold-length sweep around long threshold");
        for (int h = 14; h <= 18; h++) begin
            applyStimulus(1'b0, h);
            applyStimulus(1'b1, 10);
        end

        $display("[TB] reset mid-hold");
        applyStimulus(1'b0, 6);
        applyStimulus(1'b0, 8);
        r0 = n_rel;
        pulseReset(1'b0, 2);
        chg = m_cyc;
        applyStimulus(1'b0, 10);
        checkInt("reset_no_release", n_rel - r0, 0);
        checkInt("repress_latency", last_press_cyc - chg, 6);
        applyStimulus(1'b1, 10);

        $display("[TB] random bouncing");
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 4) == 0)
                applyStimulus(1'b0, $urandom_range(10, 25));
            else
                applyStimulus(1'($urandom_range(0, 1)), $urandom_range(1, 7));
        end
        applyStimulus(1'b1, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
